fetch_unit: RTL

- Instruction fetch stage sitting directly downstream of the program counter (`counter`, WIDTH=9).
- Reads the PC value, issues byte reads to program memory, and assembles 1-, 2- or 3-byte instructions into an instruction register.
- Presents each instruction to decode with a valid/ready handshake.
- Drives a one-cycle increment strobe back to the PC for every byte it accepts.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_len_decode.sv | 26 ++
 rtl/fetch_unit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and the decode stage that reuses its length decoder.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_OP,
    REQ_B1,
    REQ_B2,
    HOLD
  } fetch_state_t;

  localparam logic [1:0] LEN1 = 2'd1;
  localparam logic [1:0] LEN2 = 2'd2;
  localparam logic [1:0] LEN3 = 2'd3;

  // Instruction length is encoded in the top two opcode bits.
  localparam int OPC_CLASS_HI = 7;
  localparam int OPC_CLASS_LO = 6;

endpackage

// File: rtl/fetch_len_decode.sv
// Opcode class to instruction length (1..3 bytes); purely combinational, no handshake.
module fetch_len_decode
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] opcode_i,
  output logic [1:0]            len_o
);

  logic [1:0] opc_class;
  logic       unused_low_bits;

  assign opc_class       = opcode_i[OPC_CLASS_HI:OPC_CLASS_LO];
  assign unused_low_bits = ^opcode_i[OPC_CLASS_LO-1:0];

  always_comb begin
    len_o = LEN1;
    unique case (opc_class)
      2'b10:   len_o = LEN2;
      2'b11:   len_o = LEN3;
      default: len_o = LEN1;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles 1-3 byte instructions, valid one cycle after the last byte;
// stalls on mem_ready=0, holds the instruction until decode asserts ir_ready, flush restarts at the new PC.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   pc_in,
  output logic                    pc_inc,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_rd,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  input  logic                    mem_ready,
  input  logic                    flush,
  output logic [DATA_WIDTH-1:0]   ir_opcode,
  output logic [2*DATA_WIDTH-1:0] ir_operand,
  output logic [1:0]              ir_len,
  output logic [ADDR_WIDTH-1:0]   ir_pc,
  output logic                    ir_valid,
  input  logic                    ir_ready
);

  fetch_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0]   opcode_q, opcode_d;
  logic [2*DATA_WIDTH-1:0] operand_q, operand_d;
  logic [1:0]              len_q, len_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    valid_q, valid_d;
  logic [1:0]              dec_len;
  logic                    accept;

  fetch_len_decode #(.DATA_WIDTH(DATA_WIDTH)) u_len_decode (
    .opcode_i (mem_data),
    .len_o    (dec_len)
  );

  assign mem_rd   = (state_q == REQ_OP) || (state_q == REQ_B1) || (state_q == REQ_B2);
  assign accept   = mem_rd & mem_ready & ~flush;
  assign pc_inc   = accept;
  assign mem_addr = pc_in;

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    len_d     = len_q;
    pc_d      = pc_q;
    valid_d   = valid_q;

    // A flush wins over everything, including a same-cycle decode handshake.
    if (flush) begin
      state_d = REQ_OP;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: state_d = REQ_OP;
        REQ_OP: begin
          if (accept) begin
            opcode_d  = mem_data;
            pc_d      = pc_in;
            operand_d = '0;
            len_d     = dec_len;
            if (dec_len == LEN1) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              state_d = REQ_B1;
            end
          end
        end
        REQ_B1: begin
          if (accept) begin
            operand_d[DATA_WIDTH-1:0] = mem_data;
            if (len_q == LEN2) begin
              state_d = HOLD;
              valid_d = 1'b1;
            end else begin
              state_d = REQ_B2;
            end
          end
        end
        REQ_B2: begin
          if (accept) begin
            operand_d[2*DATA_WIDTH-1:DATA_WIDTH] = mem_data;
            state_d = HOLD;
            valid_d = 1'b1;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            state_d = REQ_OP;
            valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      operand_q <= '0;
      len_q     <= '0;
      pc_q      <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      len_q     <= len_d;
      pc_q      <= pc_d;
      valid_q   <= valid_d;
    end
  end

  assign ir_opcode  = opcode_q;
  assign ir_operand = operand_q;
  assign ir_len     = len_q;
  assign ir_pc      = pc_q;
  assign ir_valid   = valid_q;

endmodule
